// File: rtl/lsu_if.sv
// Bundle of the lsu's execute, memory and writeback handshakes.
// The master modport is the lsu's view; slave is the surrounding pipeline/memory.
interface lsu_if;
  logic        E_valid_i;
  logic        m_ready_o;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [3:0]  mask_i;
  logic        renMem_i;
  logic        wenMem_i;
  logic        is_load_signed_i;
  logic        wenReg_i;
  logic [4:0]  rd_i;

  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_wen_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rdata_i;

  logic        m_valid_o;
  logic        W_ready_i;
  logic        wenReg_o;
  logic [4:0]  rd_o;
  logic [63:0] wbdata_o;
  logic [4:0]  M_byp_rd_o;
  logic        misalign_o;

  modport master (
    input  E_valid_i, addr_i, wdata_i, mask_i, renMem_i, wenMem_i,
           is_load_signed_i, wenReg_i, rd_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, W_ready_i,
    output m_ready_o, mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o,
           mem_wstrb_o, m_valid_o, wenReg_o, rd_o, wbdata_o, M_byp_rd_o,
           misalign_o
  );

  modport slave (
    output E_valid_i, addr_i, wdata_i, mask_i, renMem_i, wenMem_i,
           is_load_signed_i, wenReg_i, rd_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, W_ready_i,
    input  m_ready_o, mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o,
           mem_wstrb_o, m_valid_o, wenReg_o, rd_o, wbdata_o, M_byp_rd_o,
           misalign_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit between execute and writeback: IDLE/REQ/WAIT/DONE FSM driving a 64-bit memory port.
// Define YSYX_23060251_LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module lsu (
  input  logic       clock,
  input  logic       reset,
  lsu_if.master      bus,
  output logic [1:0] dbg_state
);
  // Handshakes: a transfer happens on a cycle where valid & ready are both 1 at the rising edge;
  // a source holds valid and its payload stable until that cycle, ready never depends on the
  // same-direction valid, and the memory never responds in the cycle its request is accepted.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_n;
  logic [63:0] addr_q, wdata_q, wb_q;
  logic [1:0]  size_q;
  logic        is_store_q, sgn_q, wen_q, wen_raw_q;
  logic [4:0]  rd_q;

  logic        accept, mem_op, misaligned;
  logic [1:0]  size_in;
  logic [2:0]  off;
  logic [63:0] shifted, load_val;
  logic [7:0]  byte_en;
  state_t      go_state;

  assign mem_op = bus.renMem_i | bus.wenMem_i;
  assign off    = addr_q[2:0];

  // Access size as log2(bytes); anything that is not one-hot becomes a double.
  always_comb begin
    case (bus.mask_i)
      4'b0001: size_in = 2'd0;
      4'b0010: size_in = 2'd1;
      4'b0100: size_in = 2'd2;
      default: size_in = 2'd3;
    endcase
  end

`ifdef YSYX_23060251_LSU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_comb begin
    case (size_in)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = mem_op & bus.addr_i[0];
      2'd2:    misaligned = mem_op & (|bus.addr_i[1:0]);
      default: misaligned = mem_op & (|bus.addr_i[2:0]);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= accept & misaligned;
  end

  assign bus.misalign_o = misalign_q;
`else
  assign misaligned     = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  assign bus.m_ready_o = (state == IDLE) | ((state == DONE) & bus.W_ready_i);
  assign accept        = bus.E_valid_i & bus.m_ready_o;
  assign go_state      = (mem_op & ~misaligned) ? REQ : DONE;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = go_state;
      REQ:  if (bus.mem_req_ready_i) state_n = WAIT;
      WAIT: if (bus.mem_rsp_valid_i) state_n = DONE;
      DONE: if (bus.W_ready_i) state_n = accept ? go_state : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Load data alignment and extension from the latched offset/size.
  always_comb begin
    shifted = bus.mem_rdata_i >> {off, 3'b000};
    case (size_q)
      2'd0:    load_val = {{56{sgn_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{48{sgn_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{32{sgn_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    byte_en = 8'h01;
      2'd1:    byte_en = 8'h03;
      2'd2:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_q       <= '0;
      size_q     <= '0;
      is_store_q <= 1'b0;
      sgn_q      <= 1'b0;
      wen_q      <= 1'b0;
      wen_raw_q  <= 1'b0;
      rd_q       <= '0;
    end else if (accept) begin
      addr_q     <= bus.addr_i;
      wdata_q    <= bus.wdata_i;
      wb_q       <= bus.addr_i;
      size_q     <= size_in;
      is_store_q <= bus.wenMem_i;
      sgn_q      <= bus.is_load_signed_i;
      wen_q      <= bus.wenReg_i & ~bus.wenMem_i & ~misaligned;
      wen_raw_q  <= bus.wenReg_i;
      rd_q       <= bus.rd_i;
    end else if ((state == WAIT) && bus.mem_rsp_valid_i && !is_store_q) begin
      wb_q <= load_val;
    end
  end

  // Strobes past byte 7 fall off the 8-bit shift, truncating crossing accesses.
  assign bus.mem_req_valid_o = (state == REQ);
  assign bus.mem_addr_o      = {addr_q[63:3], 3'b000};
  assign bus.mem_wen_o       = is_store_q;
  assign bus.mem_wstrb_o     = is_store_q ? (byte_en << off) : 8'h00;
  assign bus.mem_wdata_o     = wdata_q << {off, 3'b000};

  assign bus.m_valid_o  = (state == DONE);
  assign bus.wenReg_o   = (state == DONE) & wen_q;
  assign bus.rd_o       = rd_q;
  assign bus.wbdata_o   = wb_q;
  assign bus.M_byp_rd_o = ((state != IDLE) && wen_raw_q) ? rd_q : 5'd0;

  assign dbg_state = state;
endmodule

// File: tb/tb_lsu.sv
// Directed and randomized bench for lsu; the bench plays execute stage, memory and writeback.
module tb_lsu;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  lsu_if bus();

  lsu dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference model: byte-lane view of an aligned 64-bit memory word.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int o, input int nb, input bit sgn);
    logic [63:0] r = '0;
    for (int i = 0; i < nb; i++)
      if (o + i < 8) r[8*i +: 8] = rdata[8*(o+i) +: 8];
    if (sgn && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] ref_strb(input int o, input int nb, input bit st);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = st && (i >= o) && (i < o + nb);
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int o);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (i >= o) r[8*i +: 8] = wd[8*(i-o) +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.E_valid_i = 0; bus.addr_i = '0; bus.wdata_i = '0; bus.mask_i = '0;
    bus.renMem_i = 0; bus.wenMem_i = 0; bus.is_load_signed_i = 0;
    bus.wenReg_i = 0; bus.rd_i = '0; bus.mem_req_ready_i = 0;
    bus.mem_rsp_valid_i = 0; bus.mem_rdata_i = '0; bus.W_ready_i = 0;
  endtask

  task automatic issue(input bit ren, input bit wen, input bit sgn, input bit wreg,
                       input logic [3:0] mask, input logic [4:0] rd,
                       input logic [63:0] addr, input logic [63:0] wdata);
    int n = 0;
    @(negedge clock);
    bus.E_valid_i = 1; bus.renMem_i = ren; bus.wenMem_i = wen;
    bus.is_load_signed_i = sgn; bus.wenReg_i = wreg; bus.mask_i = mask;
    bus.rd_i = rd; bus.addr_i = addr; bus.wdata_i = wdata;
    while (!bus.m_ready_o && n < 20) begin @(negedge clock); n++; end
    check("issue_ready", bus.m_ready_o, 1);
    @(posedge clock); #1;
    bus.E_valid_i = 0;
  endtask

  task automatic mem_serve(input logic [63:0] exp_addr, input bit exp_wen, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata, input logic [63:0] rdata,
                           input int stall, input logic [4:0] exp_byp);
    int n = 0;
    @(negedge clock);
    while (!bus.mem_req_valid_o && n < 20) begin @(negedge clock); n++; end
    check("req_valid", bus.mem_req_valid_o, 1);
    check("req_addr", bus.mem_addr_o, exp_addr);
    check("req_wen", bus.mem_wen_o, exp_wen);
    check("req_strb", bus.mem_wstrb_o, exp_strb);
    check("req_wdata", bus.mem_wdata_o, exp_wdata);
    check("req_byp", bus.M_byp_rd_o, exp_byp);
    repeat (stall) begin
      @(negedge clock);
      check("stall_valid", bus.mem_req_valid_o, 1);
      check("stall_addr", bus.mem_addr_o, exp_addr);
      check("stall_strb", bus.mem_wstrb_o, exp_strb);
      check("stall_wdata", bus.mem_wdata_o, exp_wdata);
      check("stall_mready", bus.m_ready_o, 0);
      check("stall_byp", bus.M_byp_rd_o, exp_byp);
    end
    bus.mem_req_ready_i = 1;
    @(posedge clock); #1;
    bus.mem_req_ready_i = 0;
    @(negedge clock);
    check("wait_no_valid", bus.m_valid_o, 0);
    check("wait_no_req", bus.mem_req_valid_o, 0);
    bus.mem_rsp_valid_i = 1; bus.mem_rdata_i = rdata;
    @(posedge clock); #1;
    bus.mem_rsp_valid_i = 0;
  endtask

  task automatic wait_result(input bit exp_wen, input logic [4:0] exp_rd,
                             input logic [63:0] exp_wb, input bit chk_wb);
    int n = 0;
    @(negedge clock);
    while (!bus.m_valid_o && n < 20) begin @(negedge clock); n++; end
    check("res_valid", bus.m_valid_o, 1);
    check("res_wen", bus.wenReg_o, exp_wen);
    check("res_rd", bus.rd_o, exp_rd);
    if (chk_wb) check("res_wbdata", bus.wbdata_o, exp_wb);
    bus.W_ready_i = 1;
    @(posedge clock); #1;
    bus.W_ready_i = 0;
  endtask

  initial begin
    logic [63:0] a, wd, rdv;
    logic [4:0]  rd;
    logic [4:0]  rd_hist[$];
    int          sz, nb, o;
    bit          st, sg;

    // Reset
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("rst_m_valid", bus.m_valid_o, 0);
    check("rst_req_valid", bus.mem_req_valid_o, 0);
    check("rst_wenreg", bus.wenReg_o, 0);
    check("rst_misalign", bus.misalign_o, 0);
    check("rst_rd", bus.rd_o, 0);
    check("rst_byp", bus.M_byp_rd_o, 0);
    check("rst_wbdata", bus.wbdata_o, 0);
    check("rst_m_ready", bus.m_ready_o, 1);

    // lb / lbu at offset 3
    issue(1, 0, 1, 1, 4'b0001, 5'd3, 64'h8000_0003, 64'h0);
    mem_serve(64'h8000_0000, 0, 8'h00, 64'h0, 64'h0000_0000_8000_0000, 0, 5'd3);
    wait_result(1, 5'd3, 64'hFFFF_FFFF_FFFF_FF80, 1);
    issue(1, 0, 0, 1, 4'b0001, 5'd4, 64'h8000_0003, 64'h0);
    mem_serve(64'h8000_0000, 0, 8'h00, 64'h0, 64'h0000_0000_8000_0000, 0, 5'd4);
    wait_result(1, 5'd4, 64'h80, 1);

    // sh at offset 6
    issue(0, 1, 0, 0, 4'b0010, 5'd0, 64'h8000_0006, 64'h1234);
    mem_serve(64'h8000_0000, 1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0, 0, 5'd0);
    wait_result(0, 5'd0, 64'h0, 0);

    // Memory stalls the request for three cycles
    issue(1, 0, 0, 1, 4'b1000, 5'd7, 64'h8000_0040, 64'h0);
    mem_serve(64'h8000_0040, 0, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567, 3, 5'd7);
    wait_result(1, 5'd7, 64'hDEAD_BEEF_0123_4567, 1);

    // Non-one-hot masks are doubles
    issue(1, 0, 1, 1, 4'b0110, 5'd8, 64'h8000_0010, 64'h0);
    mem_serve(64'h8000_0010, 0, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 5'd8);
    wait_result(1, 5'd8, 64'h8123_4567_89AB_CDEF, 1);
    issue(0, 1, 0, 0, 4'b0000, 5'd0, 64'h8000_0018, 64'hCAFE_F00D_1122_3344);
    mem_serve(64'h8000_0018, 1, 8'hFF, 64'hCAFE_F00D_1122_3344, 64'h0, 0, 5'd0);
    wait_result(0, 5'd0, 64'h0, 0);

    // Back-to-back ALU results with W always ready
    @(negedge clock);
    bus.W_ready_i = 1; bus.E_valid_i = 1; bus.renMem_i = 0; bus.wenMem_i = 0; bus.wenReg_i = 1;
    for (int k = 0; k < 6; k++) begin
      a  = (k == 0) ? 64'h5 : {$urandom, $urandom};
      rd = 5'($urandom_range(1, 31));
      bus.addr_i = a; bus.rd_i = rd;
      check("b2b_ready", bus.m_ready_o, 1);
      exp_q.push_back(a);
      rd_hist.push_back(rd);
      @(negedge clock);
      check("b2b_valid", bus.m_valid_o, 1);
      check("b2b_wen", bus.wenReg_o, 1);
      check("b2b_wbdata", bus.wbdata_o, exp_q.pop_front());
      check("b2b_rd", bus.rd_o, rd_hist.pop_front());
    end
    bus.E_valid_i = 0;
    @(negedge clock);
    bus.W_ready_i = 0;
    check("b2b_drained", bus.m_valid_o, 0);
    check("b2b_q_empty", exp_q.size(), 0);

    // Reset while waiting for the response
    issue(1, 0, 0, 1, 4'b1000, 5'd5, 64'h8000_0080, 64'h0);
    @(negedge clock);
    check("rstw_req", bus.mem_req_valid_o, 1);
    bus.mem_req_ready_i = 1;
    @(posedge clock); #1;
    bus.mem_req_ready_i = 0;
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    bus.mem_rsp_valid_i = 1; bus.mem_rdata_i = 64'h1111_2222_3333_4444;
    @(posedge clock); #1;
    bus.mem_rsp_valid_i = 0;
    repeat (3) begin
      @(negedge clock);
      check("rstw_no_valid", bus.m_valid_o, 0);
      check("rstw_idle", dbg_state, 2'd0);
      check("rstw_ready", bus.m_ready_o, 1);
      check("rstw_byp", bus.M_byp_rd_o, 0);
    end

    // lw at offset 2
    rdv = {$urandom, $urandom};
    issue(1, 0, 1, 1, 4'b0100, 5'd9, 64'h8000_0002, 64'h0000_0000_5555_AAAA);
`ifdef YSYX_23060251_LSU_MISALIGN_CHECK_EN
    @(negedge clock);
    check("mis_pulse", bus.misalign_o, 1);
    check("mis_no_req", bus.mem_req_valid_o, 0);
    check("mis_done", bus.m_valid_o, 1);
    check("mis_wen", bus.wenReg_o, 0);
    bus.W_ready_i = 1;
    @(posedge clock); #1;
    bus.W_ready_i = 0;
    @(negedge clock);
    check("mis_pulse_end", bus.misalign_o, 0);
    check("mis_idle", bus.m_valid_o, 0);
`else
    mem_serve(64'h8000_0000, 0, 8'h00, ref_wdata(64'h0000_0000_5555_AAAA, 2), rdv, 0, 5'd9);
    check("mis_off_flag", bus.misalign_o, 0);
    wait_result(1, 5'd9, ref_load(rdv, 2, 4, 1), 1);
`endif

    // Randomized naturally-aligned loads and stores
    for (int t = 0; t < 30; t++) begin
      sz  = $urandom_range(0, 3);
      nb  = 1 << sz;
      o   = $urandom_range(0, (8 / nb) - 1) * nb;
      st  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      rdv = {$urandom, $urandom};
      a   = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd8 + 64'(o);
      issue(!st, st, sg, !st, 4'(1 << sz), rd, a, wd);
      mem_serve({a[63:3], 3'b000}, st, ref_strb(o, nb, st), ref_wdata(wd, o), rdv,
                $urandom_range(0, 2), st ? 5'd0 : rd);
      wait_result(!st, rd, ref_load(rdv, o, nb, sg), !st);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- E_valid_i  in  1  execute result valid.
- m_ready_o  out  1  lsu accepts from E.
- addr_i  in  64  effective address / ALU result.
- wdata_i  in  64  store data (rs2).
- mask_i  in  4  one-hot access size, [0]=byte [1]=half [2]=word [3]=double.
- renMem_i  in  1  load.
- wenMem_i  in  1  store.
- is_load_signed_i  in  1  sign-extend load data.
- wenReg_i  in  1  instruction writes rd.
- rd_i  in  5  destination register.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_addr_o  out  64  8-byte-aligned address.
- mem_wen_o  out  1  request is a write.
- mem_wdata_o  out  64  lane-shifted store data.
- mem_wstrb_o  out  8  byte strobes.
- mem_rsp_valid_i  in  1  response valid; rdata valid on loads.
- mem_rdata_i  in  64  aligned 64-bit read data.
- m_valid_o  out  1  result valid to W.
- W_ready_i  in  1  W accepts.
- wenReg_o  out  1  writeback enable.
- rd_o  out  5  writeback register.
- wbdata_o  out  64  writeback data.
- M_byp_rd_o  out  5  rd of held instruction when wenReg, else 0 (decode stall source).
- misalign_o  out  1  one-cycle misaligned-access pulse (macro only).

Function
REQ-002 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-003 m_ready_o SHALL be 1 only in IDLE, or in DONE when W_ready_i=1; an input is accepted on E_valid_i & m_ready_o and latched.
REQ-004 Accepted non-memory instruction SHALL go to DONE next cycle with wbdata_o=addr_i (1-cycle latency).
REQ-005 Accepted load/store SHALL go to REQ; mem_req_valid_o=1 only in REQ, held stable until mem_req_ready_i; then WAIT.
REQ-006 In WAIT, mem_rsp_valid_i SHALL move to DONE, capturing load data; response in the same cycle the request is accepted is illegal from memory.
REQ-007 mem_addr_o SHALL be {addr[63:3],3'b0}; offset o=addr[2:0]; mem_wstrb_o = size bytes (1/2/4/8) shifted left by o, 0 for loads; mem_wdata_o = wdata_i << (8*o).
REQ-008 Load result SHALL be mem_rdata_i >> (8*o) truncated to size, sign-extended if is_load_signed_i, else zero-extended, to 64 bits.
REQ-009 Store SHALL complete in DONE with wenReg_o=0.
REQ-010 In DONE, m_valid_o=1; outputs stable until W_ready_i; on W_ready_i the next instruction is accepted same cycle (back-to-back) else IDLE.
REQ-011 M_byp_rd_o SHALL be the latched rd whenever state≠IDLE and latched wenReg=1, otherwise 0.
REQ-012 mask_i not one-hot on a memory op SHALL be treated as double.

Reset
REQ-013 reset SHALL force IDLE; m_valid_o, mem_req_valid_o, wenReg_o, misalign_o = 0; rd_o, M_byp_rd_o, wbdata_o = 0; m_ready_o = 1 the cycle after reset deasserts.
REQ-014 reset mid-REQ/WAIT SHALL abandon the transaction with no writeback; stale responses are ignored because the FSM is in IDLE.

Configuration
REQ-015 With YSYX_23060251_LSU_MISALIGN_CHECK_EN defined, an access where o is not a multiple of size SHALL issue no memory request, pulse misalign_o for one cycle, and go to DONE with wenReg_o=0; without it, misalign_o is tied 0 and crossing strobes are truncated to the 8-byte word.

Verification
REQ-016 lb addr=0x80000003, rdata=0x00000000_80000000 -> wbdata_o=0xFFFFFFFF_FFFFFF80; lbu -> 0x80.
REQ-017 sh addr=0x80000006, wdata=0x1234 -> mem_addr_o=0x80000000, wstrb=0xC0, wdata=0x1234_0000_0000_0000.
REQ-018 mem_req_ready_i held low 3 cycles -> request signals stable, m_ready_o=0, M_byp_rd_o=rd throughout.
REQ-019 add result 0x5, W_ready_i=1 every cycle, back-to-back ALU ops -> one result per cycle, m_ready_o stays 1.
REQ-020 reset asserted in WAIT, then mem_rsp_valid_i -> no m_valid_o, state IDLE.
REQ-021 macro on, lw addr=0x80000002 -> misalign_o pulse, no mem_req_valid_o; macro off -> request with wstrb=0 and word read at offset 2.
